wb_stage: RTL and testbench

- Writeback stage that sits directly upstream of the windowed SPARC register file.
- Buffers execute-stage results in a small FIFO and merges them with load returns, which take priority.
- Drives the register file's write, icc, Y and CWP-change controls, one retirement per cycle.
- Checks SAVE/RESTORE against the window invalid mask, raising window overflow/underflow traps and holding until acknowledged.

---
 rtl/wb_stage.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the windowed SPARC register file; FIFO-buffers execute
// results, gives load returns priority, and checks SAVE/RESTORE against WIM.
// Latency: one cycle from issue selection to the registered register-file controls.
// Backpressure: ex_ready low when the result FIFO is full or a trap is pending; loads are never stalled.
//
// Optional feature macro: WB_DBL_ALIGN_CHECK_EN
//   defined   - a double write with odd rd raises trap_illegal instead of writing
//   undefined - rd[0] of a double write is silently cleared; trap_illegal is tied low
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ex_*                        execute result (valid/ready) pushed into the FIFO
//   ld_*                        load return, issued the cycle it arrives
//   cwp_out, wim_out            current window pointer and window invalid mask from the register file
//   reg_write_en .. cwp_dec     registered single-cycle controls to the register file
//   data, wr_reg, icc_in        registered payload, held between writes
//   trap_wof/wuf/illegal        held trap flags, cleared by trap_ack
//   busy                        FIFO non-empty or not in RUN

// wb_stage_fifo: small synchronous FIFO with flush, head visible combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; flush wins over push/pop.
module wb_stage_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;

  assign head_dat = mem_q[rptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_vld) begin
        mem_d[wptr_q] = push_dat;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

module wb_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int NWINDOWS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_data,
  input  logic        ex_wr_en,
  input  logic        ex_double,
  input  logic [3:0]  ex_icc,
  input  logic        ex_icc_en,
  input  logic        ex_y_en,
  input  logic        ex_save,
  input  logic        ex_restore,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic        ld_double,
  input  logic [4:0]  cwp_out,
  input  logic [31:0] wim_out,
  output logic        reg_write_en,
  output logic [63:0] data,
  output logic [4:0]  wr_reg,
  output logic        reg_writeDouble_en,
  output logic [3:0]  icc_in,
  output logic        icc_en,
  output logic        Y_en,
  output logic        cwp_inc,
  output logic        cwp_dec,
  output logic        trap_wof,
  output logic        trap_wuf,
  output logic        trap_illegal,
  input  logic        trap_ack,
  output logic        busy
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wr_en;
    logic        dbl;
    logic [3:0]  icc;
    logic        icc_en;
    logic        y_en;
    logic        save;
    logic        restore;
  } ex_entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_SETTLE, ST_TRAP} state_e;

  state_e      state_q, state_d;
  ex_entry_t   push_entry, head;
  logic        fifo_full, fifo_empty, fifo_pop, fifo_flush, fifo_push;
  logic        new_trap;
  logic        ld_misalign, head_misalign;
  logic [4:0]  nw_save, nw_restore;

  logic        reg_write_en_q, reg_write_en_d;
  logic [63:0] data_q, data_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic        wr_dbl_q, wr_dbl_d;
  logic [3:0]  icc_in_q, icc_in_d;
  logic        icc_en_q, icc_en_d;
  logic        y_en_q, y_en_d;
  logic        cwp_inc_q, cwp_inc_d;
  logic        cwp_dec_q, cwp_dec_d;
  logic        wof_q, wof_d;
  logic        wuf_q, wuf_d;
  logic        ill_q, ill_d;

  function automatic logic [4:0] align_rd(input logic dbl, input logic [4:0] rd);
    align_rd = dbl ? {rd[4:1], 1'b0} : rd;
  endfunction

  assign push_entry = '{rd: ex_rd, data: ex_data, wr_en: ex_wr_en, dbl: ex_double,
                        icc: ex_icc, icc_en: ex_icc_en, y_en: ex_y_en,
                        save: ex_save, restore: ex_restore};

  assign ex_ready  = !fifo_full && (state_q != ST_TRAP);
  assign fifo_push = ex_valid && ex_ready;
  assign busy      = !fifo_empty || (state_q != ST_RUN);

  wb_stage_fifo #(
    .WIDTH ($bits(ex_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push_vld (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Target window of the head instruction, modulo NWINDOWS so CWP 0 SAVE hits the top window.
  assign nw_save    = 5'((int'(cwp_out) + NWINDOWS - 1) % NWINDOWS);
  assign nw_restore = 5'((int'(cwp_out) + 1) % NWINDOWS);

`ifdef WB_DBL_ALIGN_CHECK_EN
  assign ld_misalign   = ld_double & ld_rd[0];
  assign head_misalign = head.dbl & head.rd[0];
`else
  assign ld_misalign   = 1'b0;
  assign head_misalign = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    reg_write_en_d = 1'b0;
    wr_dbl_d       = 1'b0;
    icc_en_d       = 1'b0;
    y_en_d         = 1'b0;
    cwp_inc_d      = 1'b0;
    cwp_dec_d      = 1'b0;
    data_d         = data_q;
    wr_reg_d       = wr_reg_q;
    icc_in_d       = icc_in_q;
    wof_d          = wof_q;
    wuf_d          = wuf_q;
    ill_d          = ill_q;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    new_trap       = 1'b0;

    if (state_q == ST_TRAP && trap_ack) begin
      wof_d   = 1'b0;
      wuf_d   = 1'b0;
      ill_d   = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_SETTLE) begin
      state_d = ST_RUN;
    end

    // Loads always win the write port, in every state; the FIFO only pops in RUN.
    if (ld_valid) begin
      if (ld_misalign) begin
        ill_d    = 1'b1;
        new_trap = 1'b1;
      end else begin
        reg_write_en_d = 1'b1;
        wr_reg_d       = align_rd(ld_double, ld_rd);
        wr_dbl_d       = ld_double;
        data_d         = ld_data;
      end
    end else if (state_q == ST_RUN && !fifo_empty) begin
      fifo_pop = 1'b1;
      if (head_misalign) begin
        ill_d    = 1'b1;
        new_trap = 1'b1;
      end else if (head.save && wim_out[nw_save]) begin
        wof_d    = 1'b1;
        new_trap = 1'b1;
      end else if (head.restore && wim_out[nw_restore]) begin
        wuf_d    = 1'b1;
        new_trap = 1'b1;
      end else begin
        reg_write_en_d = head.wr_en;
        wr_dbl_d       = head.wr_en & head.dbl;
        wr_reg_d       = align_rd(head.dbl, head.rd);
        data_d         = head.data;
        icc_in_d       = head.icc;
        icc_en_d       = head.icc_en;
        y_en_d         = head.y_en;
        cwp_dec_d      = head.save;
        cwp_inc_d      = head.restore;
        // Hold off the next pop one cycle so its window check sees the new cwp_out.
        if (head.save || head.restore) begin
          state_d = ST_SETTLE;
        end
      end
    end

    // A trap squashes everything younger, including a result pushed this same cycle.
    if (new_trap) begin
      fifo_flush = 1'b1;
      state_d    = ST_TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      reg_write_en_q <= 1'b0;
      data_q         <= '0;
      wr_reg_q       <= '0;
      wr_dbl_q       <= 1'b0;
      icc_in_q       <= '0;
      icc_en_q       <= 1'b0;
      y_en_q         <= 1'b0;
      cwp_inc_q      <= 1'b0;
      cwp_dec_q      <= 1'b0;
      wof_q          <= 1'b0;
      wuf_q          <= 1'b0;
      ill_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      reg_write_en_q <= reg_write_en_d;
      data_q         <= data_d;
      wr_reg_q       <= wr_reg_d;
      wr_dbl_q       <= wr_dbl_d;
      icc_in_q       <= icc_in_d;
      icc_en_q       <= icc_en_d;
      y_en_q         <= y_en_d;
      cwp_inc_q      <= cwp_inc_d;
      cwp_dec_q      <= cwp_dec_d;
      wof_q          <= wof_d;
      wuf_q          <= wuf_d;
      ill_q          <= ill_d;
    end
  end

  assign reg_write_en       = reg_write_en_q;
  assign data               = data_q;
  assign wr_reg             = wr_reg_q;
  assign reg_writeDouble_en = wr_dbl_q;
  assign icc_in             = icc_in_q;
  assign icc_en             = icc_en_q;
  assign Y_en               = y_en_q;
  assign cwp_inc            = cwp_inc_q;
  assign cwp_dec            = cwp_dec_q;
  assign trap_wof           = wof_q;
  assign trap_wuf           = wuf_q;
`ifdef WB_DBL_ALIGN_CHECK_EN
  assign trap_illegal       = ill_q;
`else
  assign trap_illegal       = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
`timescale 1ns/1ps
module tb_wb_stage;
  localparam int DEPTH = 2;
  localparam int NW    = 32;
  localparam int M_RUN = 0, M_SETTLE = 1, M_TRAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ex_valid, ex_ready, ex_wr_en, ex_double, ex_icc_en, ex_y_en, ex_save, ex_restore;
  logic [4:0]  ex_rd, ld_rd, cwp_out, wr_reg;
  logic [63:0] ex_data, ld_data, data;
  logic [3:0]  ex_icc, icc_in;
  logic        ld_valid, ld_double;
  logic [31:0] wim_out;
  logic        reg_write_en, reg_writeDouble_en, icc_en, Y_en, cwp_inc, cwp_dec;
  logic        trap_wof, trap_wuf, trap_illegal, trap_ack, busy;

  wb_stage #(.FIFO_DEPTH(DEPTH), .NWINDOWS(NW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_wr_en(ex_wr_en), .ex_double(ex_double), .ex_icc(ex_icc), .ex_icc_en(ex_icc_en),
    .ex_y_en(ex_y_en), .ex_save(ex_save), .ex_restore(ex_restore),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_double(ld_double),
    .cwp_out(cwp_out), .wim_out(wim_out),
    .reg_write_en(reg_write_en), .data(data), .wr_reg(wr_reg),
    .reg_writeDouble_en(reg_writeDouble_en), .icc_in(icc_in), .icc_en(icc_en), .Y_en(Y_en),
    .cwp_inc(cwp_inc), .cwp_dec(cwp_dec), .trap_wof(trap_wof), .trap_wuf(trap_wuf),
    .trap_illegal(trap_illegal), .trap_ack(trap_ack), .busy(busy)
  );

  typedef struct packed {
    logic [4:0] rd; logic [63:0] data; logic wr_en; logic dbl; logic [3:0] icc;
    logic icc_en; logic y_en; logic save; logic restore;
  } ex_t;

  typedef struct packed {
    logic ld_valid; logic [4:0] ld_rd; logic [63:0] ld_data; logic ld_double;
    logic ex_valid; ex_t ex; logic ack; logic [31:0] wim;
  } stim_t;

  typedef struct packed {
    logic rwe; logic [63:0] data; logic [4:0] wr_reg; logic dbl; logic [3:0] icc;
    logic icc_en; logic y_en; logic inc; logic dec; logic wof; logic wuf; logic ill;
    logic rdy; logic busy;
  } obs_t;

  obs_t        exp_q[$];
  ex_t         mq[$];
  obs_t        m_out;
  int          m_state = M_RUN;
  int          cwp = 0, d1 = 0, d2 = 0;
  logic [31:0] cur_wim = '0;
  int          errors = 0, checks = 0;

  function automatic obs_t sample();
    obs_t o;
    o = '{rwe: reg_write_en, data: data, wr_reg: wr_reg, dbl: reg_writeDouble_en, icc: icc_in,
          icc_en: icc_en, y_en: Y_en, inc: cwp_inc, dec: cwp_dec, wof: trap_wof, wuf: trap_wuf,
          ill: trap_illegal, rdy: ex_ready, busy: busy};
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rwe=%b reg=%0d dbl=%b data=%h icc=%h/%b y=%b inc=%b dec=%b wof=%b wuf=%b ill=%b rdy=%b busy=%b",
                     o.rwe, o.wr_reg, o.dbl, o.data, o.icc, o.icc_en, o.y_en, o.inc, o.dec,
                     o.wof, o.wuf, o.ill, o.rdy, o.busy);
  endfunction

  // Scoreboard monitor: one expected observation per driven cycle, checked after the edge.
  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got {%s} want {%s}", $time, fmt(g), fmt(e));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic bit misaligned(input logic dbl, input logic [4:0] rd);
    bit en = 1'b0;
`ifdef WB_DBL_ALIGN_CHECK_EN
    en = 1'b1;
`endif
    return en && dbl && rd[0];
  endfunction

  // Reference model: decides what the register file sees after the coming edge.
  task automatic model(input stim_t s);
    obs_t o;
    ex_t  e;
    bit   trap, push_ok;
    int   nxt;
    o = m_out;
    o.rwe = 0; o.dbl = 0; o.icc_en = 0; o.y_en = 0; o.inc = 0; o.dec = 0;
    trap    = 0;
    nxt     = m_state;
    push_ok = s.ex_valid && (mq.size() < DEPTH) && (m_state != M_TRAP);
    if (m_state == M_TRAP && s.ack) begin
      o.wof = 0; o.wuf = 0; o.ill = 0; nxt = M_RUN;
    end else if (m_state == M_SETTLE) begin
      nxt = M_RUN;
    end
    if (s.ld_valid) begin
      if (misaligned(s.ld_double, s.ld_rd)) begin
        o.ill = 1; trap = 1;
      end else begin
        o.rwe = 1; o.dbl = s.ld_double; o.data = s.ld_data;
        o.wr_reg = s.ld_double ? (s.ld_rd & 5'b11110) : s.ld_rd;
      end
    end else if (m_state == M_RUN && mq.size() > 0) begin
      e = mq.pop_front();
      if (misaligned(e.dbl, e.rd)) begin
        o.ill = 1; trap = 1;
      end else if (e.save && s.wim[(cwp + NW - 1) % NW]) begin
        o.wof = 1; trap = 1;
      end else if (e.restore && s.wim[(cwp + 1) % NW]) begin
        o.wuf = 1; trap = 1;
      end else begin
        o.rwe = e.wr_en; o.dbl = e.wr_en && e.dbl; o.data = e.data;
        o.wr_reg = e.dbl ? (e.rd & 5'b11110) : e.rd;
        o.icc = e.icc; o.icc_en = e.icc_en; o.y_en = e.y_en;
        o.dec = e.save; o.inc = e.restore;
        if (e.save || e.restore) nxt = M_SETTLE;
      end
    end
    if (push_ok) mq.push_back(s.ex);
    if (trap) begin
      mq.delete();
      nxt = M_TRAP;
    end
    o.rdy  = (mq.size() < DEPTH) && (nxt != M_TRAP);
    o.busy = (mq.size() != 0) || (nxt != M_RUN);
    if (o.inc) d1 = 1;
    else if (o.dec) d1 = -1;
    exp_q.push_back(o);
    m_out   = o;
    m_state = nxt;
  endtask

  task automatic apply(input stim_t s);
    ld_valid = s.ld_valid; ld_rd = s.ld_rd; ld_data = s.ld_data; ld_double = s.ld_double;
    ex_valid = s.ex_valid; ex_rd = s.ex.rd; ex_data = s.ex.data; ex_wr_en = s.ex.wr_en;
    ex_double = s.ex.dbl; ex_icc = s.ex.icc; ex_icc_en = s.ex.icc_en; ex_y_en = s.ex.y_en;
    ex_save = s.ex.save; ex_restore = s.ex.restore;
    trap_ack = s.ack; wim_out = s.wim; cwp_out = 5'(cwp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.wim = cur_wim;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    r;
    s = idle();
    s.ld_valid  = ($urandom_range(0, 9) < 3);
    s.ld_rd     = 5'($urandom);
    s.ld_data   = {$urandom, $urandom};
    s.ld_double = ($urandom_range(0, 3) == 0);
    s.ex_valid  = ($urandom_range(0, 9) < 6);
    s.ex.rd     = 5'($urandom);
    s.ex.data   = {$urandom, $urandom};
    s.ex.wr_en  = ($urandom_range(0, 3) != 0);
    s.ex.dbl    = ($urandom_range(0, 3) == 0);
    s.ex.icc    = 4'($urandom);
    s.ex.icc_en = $urandom_range(0, 1) == 1;
    s.ex.y_en   = $urandom_range(0, 3) == 0;
    r = $urandom_range(0, 9);
    s.ex.save    = (r == 0);
    s.ex.restore = (r == 1);
    s.ack = (m_state == M_TRAP) && ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  // One driven cycle; the register file's CWP follows DUT pulses one cycle after they appear.
  task automatic cycle(input stim_t s);
    @(negedge clk);
    cwp = (cwp + d2 + NW) % NW;
    d2 = d1;
    d1 = 0;
    apply(s);
    model(s);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    apply(idle());
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_data"}, data, 64'd0);
    chk({tag, "_ctrl"}, 64'({reg_write_en, wr_reg, reg_writeDouble_en, icc_in, icc_en, Y_en,
                            cwp_inc, cwp_dec, trap_wof, trap_wuf, trap_illegal}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, "_ready"}, 64'(ex_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    mq.delete();
    exp_q.delete();
    m_out = '0;
    m_out.rdy = 1'b1;
    m_state = M_RUN;
    d1 = 0;
    d2 = 0;
  endtask

  initial begin
    stim_t s;
    reset = 1'b1;
    cwp = 0;
    apply(idle());
    do_reset("reset");

    // Single execute result.
    s = idle(); s.ex_valid = 1; s.ex.rd = 9; s.ex.data = 64'h1234; s.ex.wr_en = 1;
    cycle(s);
    cycle(idle());
    after_edge();
    chk("ex_single_we", 64'(reg_write_en), 64'd1);
    chk("ex_single_reg", 64'(wr_reg), 64'd9);
    chk("ex_single_data", 64'(data[31:0]), 64'h1234);
    chk("ex_single_dbl", 64'(reg_writeDouble_en), 64'd0);

    // Load and execute offered together: load first.
    s = idle(); s.ld_valid = 1; s.ld_rd = 3; s.ld_data = 5;
    s.ex_valid = 1; s.ex.rd = 4; s.ex.data = 6; s.ex.wr_en = 1;
    cycle(s);
    after_edge();
    chk("prio_ld_reg", 64'(wr_reg), 64'd3);
    chk("prio_ld_data", data, 64'd5);
    cycle(idle());
    after_edge();
    chk("prio_ex_reg", 64'(wr_reg), 64'd4);
    chk("prio_ex_data", data, 64'd6);

    // Loads every cycle keep the FIFO from draining until it fills.
    repeat (3) begin
      s = rand_stim(); s.ld_valid = 1; s.ex_valid = 1; s.ex.save = 0; s.ex.restore = 0;
      cycle(s);
    end
    after_edge();
    chk("full_ready", 64'(ex_ready), 64'd0);
    repeat (4) cycle(idle());

    // SAVE into an invalid window traps.
    cwp = 1; cur_wim = 32'h1;
    s = idle(); s.ex_valid = 1; s.ex.save = 1; s.ex.wr_en = 1; s.ex.rd = 5;
    cycle(s);
    cycle(idle());
    after_edge();
    chk("wof_flag", 64'(trap_wof), 64'd1);
    chk("wof_no_dec", 64'(cwp_dec), 64'd0);
    chk("wof_ready", 64'(ex_ready), 64'd0);
    cycle(idle());
    s = idle(); s.ack = 1;
    cycle(s);
    after_edge();
    chk("wof_ack_flag", 64'(trap_wof), 64'd0);
    chk("wof_ack_busy", 64'(busy), 64'd0);

    // RESTORE from the top window wraps to 0, then SAVE wraps back after one bubble.
    cur_wim = '0; cwp = 31;
    s = idle(); s.ex_valid = 1; s.ex.restore = 1;
    cycle(s);
    s = idle(); s.ex_valid = 1; s.ex.save = 1;
    cycle(s);
    after_edge();
    chk("wrap_inc", 64'(cwp_inc), 64'd1);
    cycle(idle());
    after_edge();
    chk("wrap_bubble", 64'({cwp_inc, cwp_dec}), 64'd0);
    cycle(idle());
    after_edge();
    chk("wrap_dec", 64'(cwp_dec), 64'd1);
    repeat (3) cycle(idle());

    // Double write to an odd register.
    s = idle(); s.ex_valid = 1; s.ex.dbl = 1; s.ex.wr_en = 1; s.ex.rd = 17;
    s.ex.data = 64'hAAAA_BBBB_CCCC_DDDD;
    cycle(s);
    cycle(idle());
    after_edge();
`ifdef WB_DBL_ALIGN_CHECK_EN
    chk("dbl_illegal", 64'(trap_illegal), 64'd1);
    chk("dbl_no_write", 64'(reg_write_en), 64'd0);
    s = idle(); s.ack = 1;
    cycle(s);
`else
    chk("dbl_reg", 64'(wr_reg), 64'd16);
    chk("dbl_en", 64'(reg_writeDouble_en), 64'd1);
    chk("dbl_data", data, 64'hAAAA_BBBB_CCCC_DDDD);
`endif
    repeat (2) cycle(idle());

    // Randomized traffic with a slowly changing window mask.
    for (int i = 0; i < 3000; i++) begin
      if (i % 24 == 0) cur_wim = ($urandom_range(0, 1) == 1) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
      cycle(rand_stim());
    end
    cur_wim = '0;
    repeat (6) begin
      s = idle(); s.ack = (m_state == M_TRAP);
      cycle(s);
    end

    // Reset with a full FIFO, then reset while trapped.
    repeat (2) begin
      s = rand_stim(); s.ld_valid = 1; s.ld_double = 0; s.ex_valid = 1; s.ack = 0;
      cycle(s);
    end
    do_reset("rst_full");
    cwp = 0; cur_wim = 32'h8000_0000;
    s = idle(); s.ex_valid = 1; s.ex.save = 1;
    cycle(s);
    cycle(idle());
    after_edge();
    chk("rst_trap_pre", 64'(trap_wof), 64'd1);
    do_reset("rst_trap");

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
